// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default constants for the 6502 run/step sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        STEP  = 2'd3
    } ctrl_state_t;

    localparam int unsigned DEF_DIV    = 6000000;
    localparam int unsigned DEF_RST_CE = 1;
    localparam int unsigned DEF_LOOP   = 15;
    localparam int unsigned DEF_CNT_W  = 8;

endpackage

// File: rtl/ce_divider.sv
// Free-running prescaler: one-cycle tick every DIV clocks plus a heartbeat that toggles per tick.
module ce_divider
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic CLK,
    input  logic R,
    output logic tick,
    output logic heartbeat
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge CLK) begin
        if (R) begin
            pre       <= '0;
            heartbeat <= 1'b0;
        end else if (tick) begin
            pre       <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            pre       <= pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the 6502 core: clock-enable strobes, core reset and auto-restart.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DIV    = DEF_DIV,
    parameter int unsigned RST_CE = DEF_RST_CE,
    parameter int unsigned LOOP   = DEF_LOOP,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             restart,
    output logic             cpu_ce,
    output logic             cpu_res,
    output logic             step_ack,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             heartbeat
);

    localparam int RC_W = (RST_CE > 1) ? $clog2(RST_CE) : 1;
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CE - 1);
    localparam logic [CNT_W-1:0] LOOP_CNT = CNT_W'(LOOP);
    localparam bit               LOOP_EN  = (LOOP != 0);

    ctrl_state_t      state, state_nx;
    logic [RC_W-1:0]  rcnt, rcnt_nx;
    logic [CNT_W-1:0] cnt_nx, cnt_inc;
    logic             ce_nx, res_nx, ack_nx;
    logic             step_s, step_d, step_rise;
    logic             tick;

    ce_divider #(.DIV(DIV)) u_div (
        .CLK       (CLK),
        .R         (R),
        .tick      (tick),
        .heartbeat (heartbeat)
    );

    // Registered copy first, then edge detect: a held request yields one step only.
    assign step_rise = step_s & ~step_d;
    assign cnt_inc   = cycle_cnt + CNT_W'(1);

    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        cnt_nx   = cycle_cnt;
        ce_nx    = 1'b0;
        ack_nx   = 1'b0;
        unique case (state)
            RESET: begin
                ce_nx = tick;
                if (tick) begin
                    if (rcnt == RST_LAST) begin
                        rcnt_nx  = '0;
                        cnt_nx   = '0;
                        state_nx = run_req ? RUN : HALT;
                    end else begin
                        rcnt_nx  = rcnt + RC_W'(1);
                    end
                end
            end
            RUN: begin
                ce_nx = tick;
                if (tick) cnt_nx = cnt_inc;
                if (tick && LOOP_EN && (cnt_inc == LOOP_CNT)) state_nx = RESET;
                else if (!run_req)                            state_nx = HALT;
            end
            HALT: begin
                if (run_req)        state_nx = RUN;
                else if (step_rise) state_nx = STEP;
            end
            STEP: begin
                if (tick) begin
                    ce_nx    = 1'b1;
                    ack_nx   = 1'b1;
                    cnt_nx   = cnt_inc;
                    state_nx = HALT;
                end
            end
            default: state_nx = RESET;
        endcase
        // An already-due strobe still goes out, but under reset and not as a step grant.
        if (restart) begin
            state_nx = RESET;
            rcnt_nx  = '0;
            ack_nx   = 1'b0;
        end
        // Reset stays high through the final RESET strobe and drops one cycle later.
        res_nx = (state == RESET) || (state_nx == RESET);
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            state     <= RESET;
            rcnt      <= '0;
            cycle_cnt <= '0;
            cpu_ce    <= 1'b0;
            cpu_res   <= 1'b1;
            step_ack  <= 1'b0;
            halted    <= 1'b0;
            step_s    <= 1'b0;
            step_d    <= 1'b0;
        end else begin
            state     <= state_nx;
            rcnt      <= rcnt_nx;
            cycle_cnt <= cnt_nx;
            cpu_ce    <= ce_nx;
            cpu_res   <= res_nx;
            step_ack  <= ack_nx;
            halted    <= (state == HALT);
            step_s    <= step_req;
            step_d    <= step_s;
        end
    end

endmodule
